// File: rtl/dispatch_scoreboard.sv
// Multi-way in-order dispatch with a per-register counting scoreboard.
// Optional macro DISPATCH_WB_BYPASS_EN lets same-cycle writebacks satisfy source readiness.
module dispatch_scoreboard #(
    parameter int unsigned NUM_REGS    = 16,
    parameter int unsigned REG_ID_W    = 5,
    parameter int unsigned ISSUE_WIDTH = 2,
    parameter int unsigned NUM_PIPES   = 2,
    parameter int unsigned PEND_W      = 2
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [ISSUE_WIDTH-1:0]            mop_valid,
    input  logic [ISSUE_WIDTH*REG_ID_W-1:0]   mop_src0,
    input  logic [ISSUE_WIDTH*REG_ID_W-1:0]   mop_src1,
    input  logic [ISSUE_WIDTH*REG_ID_W-1:0]   mop_dst,
    output logic [$clog2(ISSUE_WIDTH+1)-1:0]  mop_take,
    input  logic [NUM_PIPES-1:0]              pipe_busy,
    output logic [NUM_PIPES-1:0]              pipe_issue,
    output logic [NUM_PIPES*2-1:0]            pipe_slot,
    input  logic [NUM_PIPES-1:0]              wb_valid,
    input  logic [NUM_PIPES*REG_ID_W-1:0]     wb_dst,
    output logic [NUM_REGS-1:0]               sb_busy,
    output logic                              sb_err,
    output logic [31:0]                       stall_cnt
);
    localparam int unsigned        TAKE_W  = $clog2(ISSUE_WIDTH + 1);
    localparam logic [REG_ID_W-1:0] NIL_ID = '1;
    localparam logic [7:0]         MAX_CNT = 8'((1 << PEND_W) - 1);

    logic [PEND_W-1:0]      cnt     [NUM_REGS];
    logic [PEND_W-1:0]      cnt_nx  [NUM_REGS];
    logic [7:0]             wb_dec  [NUM_REGS];
    logic [7:0]             dst_inc [NUM_REGS];
    logic [7:0]             cnt_sum [NUM_REGS];
    logic                   reg_clear [NUM_REGS];
    logic                   wb_hit;
    logic                   wb_bad;
    logic                   err_next;
    logic [ISSUE_WIDTH-1:0] issued;
    logic [NUM_PIPES-1:0]   pipe_taken;
    logic                   go;
    logic                   ok;
    logic                   pick_found;
    int unsigned            pick;
    logic [7:0]             same_dst;
    logic [REG_ID_W-1:0]    s0, s1, d, jd;

    // Ids outside 0..NUM_REGS-1 (including nil) never match a counter, so a
    // writeback to one of them is flagged as an error.
    always_comb begin : wb_count
        wb_bad = 1'b0;
        wb_hit = 1'b0;
        for (int unsigned r = 0; r < NUM_REGS; r++) wb_dec[r] = '0;
        for (int unsigned p = 0; p < NUM_PIPES; p++) begin
            wb_hit = 1'b0;
            if (wb_valid[p]) begin
                for (int unsigned r = 0; r < NUM_REGS; r++) begin
                    if (wb_dst[p*REG_ID_W +: REG_ID_W] == REG_ID_W'(r)) begin
                        wb_dec[r] = wb_dec[r] + 8'd1;
                        wb_hit    = 1'b1;
                    end
                end
                if (!wb_hit) wb_bad = 1'b1;
            end
        end
    end

    always_comb begin : readiness
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
`ifdef DISPATCH_WB_BYPASS_EN
            reg_clear[r] = (8'(cnt[r]) <= wb_dec[r]);
`else
            reg_clear[r] = (cnt[r] == '0);
`endif
        end
    end

    always_comb begin : issue
        issued     = '0;
        pipe_issue = '0;
        pipe_slot  = '0;
        mop_take   = '0;
        pipe_taken = pipe_busy;
        go         = !reset;
        ok         = 1'b0;
        pick_found = 1'b0;
        pick       = 0;
        same_dst   = '0;
        s0 = '0; s1 = '0; d = '0; jd = '0;
        for (int unsigned k = 0; k < ISSUE_WIDTH; k++) begin
            s0       = mop_src0[k*REG_ID_W +: REG_ID_W];
            s1       = mop_src1[k*REG_ID_W +: REG_ID_W];
            d        = mop_dst[k*REG_ID_W +: REG_ID_W];
            ok       = go && mop_valid[k];
            same_dst = '0;
            for (int unsigned j = 0; j < k; j++) begin
                if (issued[j]) begin
                    jd = mop_dst[j*REG_ID_W +: REG_ID_W];
                    if (s0 != NIL_ID && jd == s0) ok = 1'b0;
                    if (s1 != NIL_ID && jd == s1) ok = 1'b0;
                    if (d != NIL_ID && jd == d) same_dst = same_dst + 8'd1;
                end
            end
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                if (s0 == REG_ID_W'(r) && !reg_clear[r]) ok = 1'b0;
                if (s1 == REG_ID_W'(r) && !reg_clear[r]) ok = 1'b0;
                if (d == REG_ID_W'(r) && (8'(cnt[r]) + same_dst >= MAX_CNT)) ok = 1'b0;
            end
            pick_found = 1'b0;
            pick       = 0;
            for (int unsigned p = 0; p < NUM_PIPES; p++) begin
                if (!pick_found && !pipe_taken[p]) begin
                    pick       = p;
                    pick_found = 1'b1;
                end
            end
            if (!pick_found) ok = 1'b0;
            if (ok) begin
                issued[k]              = 1'b1;
                pipe_taken[pick]       = 1'b1;
                pipe_issue[pick]       = 1'b1;
                pipe_slot[pick*2 +: 2] = 2'(k);
                mop_take               = mop_take + TAKE_W'(1);
            end else begin
                go = 1'b0;
            end
        end
    end

    always_comb begin : cnt_next
        err_next = wb_bad;
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            dst_inc[r] = '0;
            for (int unsigned k = 0; k < ISSUE_WIDTH; k++) begin
                if (issued[k] && mop_dst[k*REG_ID_W +: REG_ID_W] == REG_ID_W'(r))
                    dst_inc[r] = dst_inc[r] + 8'd1;
            end
            cnt_sum[r] = 8'(cnt[r]) + dst_inc[r];
            if (wb_dec[r] > cnt_sum[r]) begin
                cnt_nx[r] = '0;
                err_next  = 1'b1;
            end else begin
                cnt_nx[r] = PEND_W'(cnt_sum[r] - wb_dec[r]);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
            sb_err    <= 1'b0;
            stall_cnt <= '0;
        end else begin
            for (int unsigned r = 0; r < NUM_REGS; r++) cnt[r] <= cnt_nx[r];
            if (err_next) sb_err <= 1'b1;
            if (mop_valid[0] && mop_take == '0) stall_cnt <= stall_cnt + 32'd1;
        end
    end

    always_comb begin
        for (int unsigned r = 0; r < NUM_REGS; r++) sb_busy[r] = (cnt[r] != '0);
    end
endmodule

// File: tb/tb_dispatch_scoreboard.sv
// Directed table-driven bench for dispatch_scoreboard plus multi-cycle corner sequences.
module tb_dispatch_scoreboard;
    localparam int N = 31;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  mop_valid;
    logic [9:0]  mop_src0, mop_src1, mop_dst;
    logic [1:0]  mop_take;
    logic [1:0]  pipe_busy, pipe_issue, wb_valid;
    logic [3:0]  pipe_slot;
    logic [9:0]  wb_dst;
    logic [15:0] sb_busy;
    logic        sb_err;
    logic [31:0] stall_cnt;

    int passed = 0;
    int total  = 0;

    dispatch_scoreboard #(
        .NUM_REGS(16), .REG_ID_W(5), .ISSUE_WIDTH(2), .NUM_PIPES(2), .PEND_W(2)
    ) dut (
        .clk(clk), .reset(reset),
        .mop_valid(mop_valid), .mop_src0(mop_src0), .mop_src1(mop_src1), .mop_dst(mop_dst),
        .mop_take(mop_take), .pipe_busy(pipe_busy), .pipe_issue(pipe_issue), .pipe_slot(pipe_slot),
        .wb_valid(wb_valid), .wb_dst(wb_dst),
        .sb_busy(sb_busy), .sb_err(sb_err), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  mv;
        logic [9:0]  s0, s1, d;
        logic [1:0]  pb, wv;
        logic [9:0]  wd;
        logic [1:0]  take, iss;
        logic [3:0]  slot;
        logic [15:0] busy;
        logic [31:0] stall;
    } vec_t;

    vec_t tbl [13];

    function automatic logic [9:0] ids(input int a, input int b);
        return {5'(b), 5'(a)};
    endfunction

    function automatic vec_t v(input logic [1:0] mv, input logic [9:0] s0, input logic [9:0] s1,
                               input logic [9:0] d, input logic [1:0] pb, input logic [1:0] wv,
                               input logic [9:0] wd, input logic [1:0] take, input logic [1:0] iss,
                               input logic [3:0] slot, input logic [15:0] busy, input int stall);
        vec_t t;
        t.mv = mv; t.s0 = s0; t.s1 = s1; t.d = d; t.pb = pb; t.wv = wv; t.wd = wd;
        t.take = take; t.iss = iss; t.slot = slot; t.busy = busy; t.stall = 32'(stall);
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive(input logic [1:0] mv, input logic [9:0] s0, input logic [9:0] s1,
                         input logic [9:0] d, input logic [1:0] pb, input logic [1:0] wv,
                         input logic [9:0] wd);
        mop_valid = mv; mop_src0 = s0; mop_src1 = s1; mop_dst = d;
        pipe_busy = pb; wb_valid = wv; wb_dst = wd;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int s;
`ifdef DISPATCH_WB_BYPASS_EN
        s = 1;
`else
        s = 2;
`endif
        tbl[0]  = v(2'b00, ids(N,N), ids(N,N), ids(N,N), 2'b00, 2'b00, ids(N,N), 0, 2'b00, 4'h0, 16'h0000, 0);
        tbl[1]  = v(2'b11, ids(2,5), ids(3,6), ids(1,4), 2'b00, 2'b00, ids(N,N), 2, 2'b11, 4'b0100, 16'h0012, 0);
        tbl[2]  = v(2'b00, ids(N,N), ids(N,N), ids(N,N), 2'b00, 2'b11, ids(1,4), 0, 2'b00, 4'h0, 16'h0000, 0);
        tbl[3]  = v(2'b11, ids(N,1), ids(N,N), ids(1,2), 2'b00, 2'b00, ids(N,N), 1, 2'b01, 4'h0, 16'h0002, 0);
        tbl[4]  = v(2'b01, ids(1,N), ids(N,N), ids(2,N), 2'b00, 2'b00, ids(N,N), 0, 2'b00, 4'h0, 16'h0002, 1);
`ifdef DISPATCH_WB_BYPASS_EN
        tbl[5]  = v(2'b01, ids(1,N), ids(N,N), ids(2,N), 2'b00, 2'b01, ids(1,N), 1, 2'b01, 4'h0, 16'h0004, 1);
        tbl[6]  = v(2'b00, ids(1,N), ids(N,N), ids(2,N), 2'b00, 2'b00, ids(N,N), 0, 2'b00, 4'h0, 16'h0004, 1);
`else
        tbl[5]  = v(2'b01, ids(1,N), ids(N,N), ids(2,N), 2'b00, 2'b01, ids(1,N), 0, 2'b00, 4'h0, 16'h0000, 2);
        tbl[6]  = v(2'b01, ids(1,N), ids(N,N), ids(2,N), 2'b00, 2'b00, ids(N,N), 1, 2'b01, 4'h0, 16'h0004, 2);
`endif
        tbl[7]  = v(2'b00, ids(N,N), ids(N,N), ids(N,N), 2'b00, 2'b10, ids(N,2), 0, 2'b00, 4'h0, 16'h0000, s);
        tbl[8]  = v(2'b11, ids(N,N), ids(N,N), ids(5,6), 2'b01, 2'b00, ids(N,N), 1, 2'b10, 4'h0, 16'h0020, s);
        tbl[9]  = v(2'b01, ids(N,N), ids(N,N), ids(6,N), 2'b11, 2'b00, ids(N,N), 0, 2'b00, 4'h0, 16'h0020, s+1);
        tbl[10] = v(2'b01, ids(N,N), ids(N,N), ids(6,N), 2'b11, 2'b00, ids(N,N), 0, 2'b00, 4'h0, 16'h0020, s+2);
        tbl[11] = v(2'b11, ids(N,N), ids(N,N), ids(6,7), 2'b10, 2'b00, ids(N,N), 1, 2'b01, 4'h0, 16'h0060, s+2);
        tbl[12] = v(2'b00, ids(N,N), ids(N,N), ids(N,N), 2'b00, 2'b11, ids(5,6), 0, 2'b00, 4'h0, 16'h0000, s+2);

        // reset state, with a ready micro-op presented that must not issue
        reset = 1'b1;
        drive(2'b01, ids(N,N), ids(N,N), ids(3,N), 2'b00, 2'b00, ids(N,N));
        #2;
        check("rst take", mop_take, 0);
        check("rst issue", pipe_issue, 0);
        check("rst busy", sb_busy, 0);
        check("rst err", sb_err, 0);
        check("rst stall", stall_cnt, 0);
        #5 reset = 1'b0;
        drive(2'b00, ids(N,N), ids(N,N), ids(N,N), 2'b00, 2'b00, ids(N,N));
        @(posedge clk); #1;

        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].mv, tbl[i].s0, tbl[i].s1, tbl[i].d, tbl[i].pb, tbl[i].wv, tbl[i].wd);
            #1;
            check($sformatf("v%0d take", i), mop_take, tbl[i].take);
            check($sformatf("v%0d issue", i), pipe_issue, tbl[i].iss);
            if (tbl[i].iss != 2'b00) check($sformatf("v%0d slot", i), pipe_slot, tbl[i].slot);
            @(posedge clk); #1;
            check($sformatf("v%0d busy", i), sb_busy, tbl[i].busy);
            check($sformatf("v%0d stall", i), stall_cnt, tbl[i].stall);
            check($sformatf("v%0d err", i), sb_err, 0);
        end

        // WAW saturation on r7
        for (int i = 0; i < 3; i++) begin
            drive(2'b01, ids(N,N), ids(N,N), ids(7,N), 2'b00, 2'b00, ids(N,N));
            #1 check($sformatf("waw%0d take", i), mop_take, 1);
            @(posedge clk); #1;
        end
        #1 check("waw sat take", mop_take, 0);
        @(posedge clk); #1;
        check("waw sat busy", sb_busy, 16'h0080);
        drive(2'b01, ids(N,N), ids(N,N), ids(7,N), 2'b00, 2'b01, ids(7,N));
        #1 check("waw wb take", mop_take, 0);
        @(posedge clk); #1;
        drive(2'b01, ids(N,N), ids(N,N), ids(7,N), 2'b00, 2'b00, ids(N,N));
        #1 check("waw after wb take", mop_take, 1);
        @(posedge clk); #1;
        drive(2'b00, ids(N,N), ids(N,N), ids(N,N), 2'b00, 2'b11, ids(7,7));
        @(posedge clk); #1;
        check("waw drain2 busy", sb_busy, 16'h0080);
        drive(2'b00, ids(N,N), ids(N,N), ids(N,N), 2'b00, 2'b01, ids(7,N));
        @(posedge clk); #1;
        check("waw drain busy", sb_busy, 0);
        check("waw drain err", sb_err, 0);
        check("waw stall", stall_cnt, 32'(s + 4));

        // writeback to an idle register sets the sticky error
        drive(2'b00, ids(N,N), ids(N,N), ids(N,N), 2'b00, 2'b01, ids(9,N));
        @(posedge clk); #1;
        check("err set", sb_err, 1);
        check("err busy", sb_busy, 0);
        drive(2'b01, ids(N,N), ids(N,N), ids(10,N), 2'b00, 2'b00, ids(N,N));
        @(posedge clk); #1;
        check("err sticky", sb_err, 1);
        check("r10 busy", sb_busy, 16'h0400);

        // async reset in the middle of a low-high phase
        drive(2'b01, ids(N,N), ids(N,N), ids(11,N), 2'b00, 2'b00, ids(N,N));
        #3 reset = 1'b1;
        #1;
        check("async err", sb_err, 0);
        check("async busy", sb_busy, 0);
        check("async take", mop_take, 0);
        check("async issue", pipe_issue, 0);
        check("async stall", stall_cnt, 0);
        #2 reset = 1'b0;
        drive(2'b01, ids(N,N), ids(N,N), ids(9,N), 2'b00, 2'b00, ids(N,N));
        @(posedge clk); #1;

        // double writeback to a count-1 register clamps at zero and flags error
        check("clamp pre busy", sb_busy, 16'h0200);
        drive(2'b00, ids(N,N), ids(N,N), ids(N,N), 2'b00, 2'b11, ids(9,9));
        @(posedge clk); #1;
        check("clamp busy", sb_busy, 0);
        check("clamp err", sb_err, 1);

        // nil writeback id is an error
        #2 reset = 1'b1;
        #2 reset = 1'b0;
        check("nil pre err", sb_err, 0);
        drive(2'b00, ids(N,N), ids(N,N), ids(N,N), 2'b00, 2'b01, ids(N,N));
        @(posedge clk); #1;
        check("nil err", sb_err, 1);
        check("nil busy", sb_busy, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/dispatch_scoreboard.md
Name: dispatch_scoreboard

Overview:
- Multi-way in-order dispatch stage with a counting scoreboard. It sits between the micro-op decode queue and N execution pipelines, and generalises the single-way, single-pipe, toggle-bit scoreboard dispatch.
- Each cycle it examines up to ISSUE_WIDTH head micro-ops and issues an in-order prefix of them to free pipes.
- It tracks multiple in-flight writers per register and retires them on writeback.

Parameters:
- NUM_REGS, 16, architectural registers tracked (ids 0..NUM_REGS-1).
- REG_ID_W, 5, register-id width; id all-ones = nil (no register).
- ISSUE_WIDTH, 2, head micro-op slots examined per cycle (1..4).
- NUM_PIPES, 2, execution pipelines (>= ISSUE_WIDTH).
- PEND_W, 2, width of the per-register pending-writer counter; max = 2^PEND_W-1.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- mop_valid  in  ISSUE_WIDTH  slot k holds a valid micro-op (contiguous from slot 0)
- mop_src0  in  ISSUE_WIDTH*REG_ID_W  source 0 id per slot
- mop_src1  in  ISSUE_WIDTH*REG_ID_W  source 1 id per slot
- mop_dst  in  ISSUE_WIDTH*REG_ID_W  destination id per slot
- mop_take  out  $clog2(ISSUE_WIDTH+1)  slots consumed this cycle (queue dequeue count)
- pipe_busy  in  NUM_PIPES  pipe cannot accept this cycle
- pipe_issue  out  NUM_PIPES  pipe p receives a micro-op this cycle
- pipe_slot  out  NUM_PIPES*2  slot index routed to pipe p (valid when pipe_issue[p])
- wb_valid  in  NUM_PIPES  pipe p retires a write this cycle
- wb_dst  in  NUM_PIPES*REG_ID_W  register written by pipe p
- sb_busy  out  NUM_REGS  per-register pending count != 0 (registered view)
- sb_err  out  1  sticky: writeback to a register whose count is 0, or a nil id on wb_valid
- stall_cnt  out  32  cycles in which slot 0 was valid but not issued

Behaviour:
- Reset (async, active-high): all counters = 0, sb_err = 0, stall_cnt = 0. While reset is high, mop_take = 0 and pipe_issue = 0.
- Issue is combinational from inputs plus registered counters. Scoreboard updates on posedge clk.
- Slot k issues only if all of the following hold:
  - mop_valid[k] is set and slots 0..k-1 issue this cycle (strict in-order prefix).
  - Every non-nil source has count 0.
  - No earlier issuing slot in the same cycle has dst equal to that source (intra-group RAW stall).
  - A non-nil dst has count < max, after counting earlier same-cycle slots writing the same dst.
  - A free pipe remains.
- Pipe assignment: issuing slots take the lowest-indexed non-busy pipes in ascending slot order.
- mop_take = number of issued slots.
- Counter update per register r: next = count + (issued slots with dst r) - (wb_valid pipes with wb_dst r).
  - Simultaneous increment and decrement on the same register net out.
  - Decrement below 0 is clamped to 0 and sets sb_err.
- Nil dst: no counter change. Nil wb_dst with wb_valid set sets sb_err and changes nothing.
- WAW to a busy register is allowed up to saturation; a saturated dst stalls the slot.
- Writeback readiness: a source cleared by writeback in cycle t is first issuable in cycle t+1 (see optional feature).
- stall_cnt increments when mop_valid[0] && mop_take == 0. It wraps at 2^32.
- sb_busy is driven from the registered counters.

Optional Feature:
- Macro: DISPATCH_WB_BYPASS_EN.
- Defined: the readiness check uses count minus same-cycle writebacks to that register. A source whose last pending writer retires in cycle t may issue in cycle t, which removes one cycle of RAW latency.
- Undefined: readiness uses the registered count only.
- Counter update arithmetic is identical in both builds.

Test Plan:
- Independent pair: reset, then slots {dst r1, src r2/r3} and {dst r4, src r5/r6}, both pipes free -> mop_take=2, pipe_issue=2'b11, pipe_slot {0,1}. Next cycle sb_busy[1] and sb_busy[4] are set.
- Intra-group RAW: slot0 dst r1, slot1 src0 r1 -> mop_take=1, only pipe0 issues. Slot1 stalls until wb_valid on r1.
- Writeback timing: r3 count=1, slot0 src r3, wb on r3 in cycle t -> without the macro slot0 issues at t+1; with DISPATCH_WB_BYPASS_EN it issues at t. sb_busy[3]=0 at t+1 in both builds.
- WAW saturation (PEND_W=2): four consecutive issues to dst r7 with no writeback -> the first three issue, the fourth stalls with count=3. One wb on r7 lets it issue the next cycle.
- Pipe pressure: pipe_busy=2'b01, two independent slots -> mop_take=1, pipe_issue=2'b10, pipe_slot[1]=0, stall_cnt unchanged. With pipe_busy=2'b11 and slot0 valid -> stall_cnt increments by 1 per cycle.
- Error and reset: wb_valid on r9 with count 0 -> sb_err=1 and stays set. Asserting reset mid-stream (async, not aligned to clk) -> sb_err=0, all sb_busy=0 and mop_take=0 immediately.
